rv32i_ctrl_fsm: RTL and testbench

Multicycle control FSM for the RV32I core, instantiated in top next to memory, register_file, alu and imm_gen. It sequences fetch/decode/execute/memory/writeback and drives every load enable, write enable and mux select in the datapath. All datapath registers (pc, instruction register, operands) live outside this block; it only decodes the instruction fields the datapath feeds it.

---
 rtl/rv32i_ctrl_pkg.sv | 46 ++++
 rtl/rv32i_alu_decoder.sv | 37 +++
 rtl/rv32i_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_rv32i_ctrl_fsm.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control path.
// State, ALU operation, mux-select encodings and opcode constants.
package rv32i_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_ctl_t;

    typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JALR} pc_src_t;
    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} alu_src_a_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_ctl_t alu_op(input logic [2:0] funct3, input logic alt);
        alu_ctl_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational ALU operation and operand-select decode from instruction fields.
import rv32i_ctrl_pkg::*;

module rv32i_alu_decoder (
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output alu_ctl_t    alu_ctl,
    output alu_src_a_t  alu_src_a,
    output logic        alu_src_b
);

    always_comb begin
        alu_ctl   = ALU_ADD;
        alu_src_a = SRC_A_RS1;
        alu_src_b = 1'b0;
        case (opcode)
            OP_R: alu_ctl = alu_op(funct3, funct7_5);
            OP_IMM: begin
                // no SUBI: bit 30 only matters for the shift-right pair
                alu_ctl   = alu_op(funct3, funct7_5 && (funct3 == 3'b101));
                alu_src_b = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: alu_src_b = 1'b1;
            OP_AUIPC, OP_JAL: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = 1'b1;
            end
            OP_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional CTRL_PERF_COUNTERS_EN adds cycle_count/instret_count outputs.
import rv32i_ctrl_pkg::*;

module rv32i_ctrl_fsm #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        branch_cond,
    output logic        ir_load,
    output logic        pc_load,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [3:0]  alu_ctl,
    output logic        regfile_wren,
    output logic [1:0]  wb_sel,
    output logic        dmem_wren,
    output logic        illegal_instr,
    output logic [2:0]  state_out
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY);

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           set_illegal;
    logic           pc_load_raw, rf_wren_raw, dm_wren_raw;
    pc_src_t        pc_sel;
    alu_src_a_t     a_sel, dec_a;
    alu_ctl_t       ctl, dec_ctl;
    wb_sel_t        wb;
    logic           b_sel, dec_b;
    logic           is_branch, is_load, is_store, is_jal, is_jalr, is_nop, legal;

    rv32i_alu_decoder u_dec (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_ctl   (dec_ctl),
        .alu_src_a (dec_a),
        .alu_src_b (dec_b)
    );

    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_nop    = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);

    always_comb begin
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            cnt           <= '0;
            illegal_instr <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (set_illegal) illegal_instr <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        set_illegal = 1'b0;
        ir_load     = 1'b0;
        pc_load_raw = 1'b0;
        rf_wren_raw = 1'b0;
        dm_wren_raw = 1'b0;
        pc_sel      = PC_PLUS4;
        a_sel       = SRC_A_RS1;
        b_sel       = 1'b0;
        ctl         = ALU_ADD;
        wb          = WB_ALU;
        case (state)
            S_FETCH: begin
                if (cnt == LAST) begin
                    ir_load    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_DECODE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_DECODE: begin
                set_illegal = !legal;
                state_next  = legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                a_sel = dec_a;
                b_sel = dec_b;
                ctl   = dec_ctl;
                if (is_branch) begin
                    pc_load_raw = 1'b1;
                    pc_sel      = branch_cond ? PC_BRANCH : PC_PLUS4;
                    state_next  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_next = S_MEMORY;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (is_store) begin
                    dm_wren_raw = 1'b1;
                    pc_load_raw = 1'b1;
                    state_next  = S_FETCH;
                end else if (cnt == LAST) begin
                    cnt_next   = '0;
                    state_next = S_WRITEBACK;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_WRITEBACK: begin
                rf_wren_raw = !is_nop;
                pc_load_raw = 1'b1;
                pc_sel      = is_jal ? PC_BRANCH : (is_jalr ? PC_JALR : PC_PLUS4);
                wb          = is_load ? WB_MEM : ((is_jal || is_jalr) ? WB_PC4 : WB_ALU);
                state_next  = S_FETCH;
            end
            default: state_next = S_TRAP;
        endcase
    end

    // architectural side effects never escape a reset cycle
    assign pc_load      = pc_load_raw && !reset;
    assign regfile_wren = rf_wren_raw && !reset;
    assign dmem_wren    = dm_wren_raw && !reset;
    assign pc_src       = pc_sel;
    assign alu_src_a    = a_sel;
    assign alu_src_b    = b_sel;
    assign alu_ctl      = ctl;
    assign wb_sel       = wb;
    assign state_out    = state;

`ifdef CTRL_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (pc_load) instret_count <= instret_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed bench: two control FSMs (MEM_LATENCY 1 and 2) checked per cycle against a trace scoreboard.
import rv32i_ctrl_pkg::*;

module tb_rv32i_ctrl_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_load;
        logic       pc_load;
        logic [1:0] pc_src;
        logic [3:0] alu_ctl;
        logic [1:0] src_a;
        logic       src_b;
        logic       rf_wren;
        logic [1:0] wb_sel;
        logic       dm_wren;
        logic       ill;
    } obs_t;

    localparam int C_ALU = 0, C_BR = 1, C_LD = 2, C_ST = 3;
    localparam int C_JAL = 4, C_JALR = 5, C_NOP = 6, C_ILL = 7;

    logic       clk, reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, branch_cond;
    obs_t       o1, o2;
    obs_t       q1[$], q2[$];
    int         total = 0, bad = 0;
`ifdef CTRL_PERF_COUNTERS_EN
    logic [31:0] cc1, ic1, cc2, ic2;
`endif

    rv32i_ctrl_fsm #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .branch_cond(branch_cond),
        .ir_load(o1.ir_load), .pc_load(o1.pc_load), .pc_src(o1.pc_src),
        .alu_src_a(o1.src_a), .alu_src_b(o1.src_b), .alu_ctl(o1.alu_ctl),
        .regfile_wren(o1.rf_wren), .wb_sel(o1.wb_sel), .dmem_wren(o1.dm_wren),
        .illegal_instr(o1.ill), .state_out(o1.st)
`ifdef CTRL_PERF_COUNTERS_EN
        , .cycle_count(cc1), .instret_count(ic1)
`endif
    );

    rv32i_ctrl_fsm #(.MEM_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .branch_cond(branch_cond),
        .ir_load(o2.ir_load), .pc_load(o2.pc_load), .pc_src(o2.pc_src),
        .alu_src_a(o2.src_a), .alu_src_b(o2.src_b), .alu_ctl(o2.alu_ctl),
        .regfile_wren(o2.rf_wren), .wb_sel(o2.wb_sel), .dmem_wren(o2.dm_wren),
        .illegal_instr(o2.ill), .state_out(o2.st)
`ifdef CTRL_PERF_COUNTERS_EN
        , .cycle_count(cc2), .instret_count(ic2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int w, input obs_t e);
        if (w == 1) q1.push_back(e);
        else        q2.push_back(e);
    endtask

    // Expected per-cycle outputs for one instruction, from reset release to return to FETCH
    task automatic model(input int w, input int lat, input int cls, input logic bc,
                         input logic [3:0] alu, input logic [1:0] a, input logic b);
        obs_t e;
        for (int i = 0; i <= lat; i++) begin
            e = '0; e.ir_load = (i == lat); push(w, e);
        end
        e = '0; e.st = 3'd1; push(w, e);
        if (cls == C_ILL) begin
            for (int i = 0; i < 20; i++) begin
                e = '0; e.st = 3'd5; e.ill = 1'b1; push(w, e);
            end
            return;
        end
        e = '0; e.st = 3'd2; e.alu_ctl = alu; e.src_a = a; e.src_b = b;
        if (cls == C_BR) begin
            e.pc_load = 1'b1; e.pc_src = {1'b0, bc};
        end
        push(w, e);
        if (cls == C_ST) begin
            e = '0; e.st = 3'd3; e.dm_wren = 1'b1; e.pc_load = 1'b1; push(w, e);
        end else if (cls != C_BR) begin
            if (cls == C_LD)
                for (int i = 0; i <= lat; i++) begin
                    e = '0; e.st = 3'd3; push(w, e);
                end
            e = '0; e.st = 3'd4; e.pc_load = 1'b1;
            e.rf_wren = (cls != C_NOP);
            e.pc_src  = (cls == C_JAL) ? 2'd1 : ((cls == C_JALR) ? 2'd2 : 2'd0);
            e.wb_sel  = (cls == C_LD) ? 2'd1 : ((cls == C_JAL || cls == C_JALR) ? 2'd2 : 2'd0);
            push(w, e);
        end
        e = '0; push(w, e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_L1", 32'(o1), 32'd0);
        chk("reset_L2", 32'(o2), 32'd0);
`ifdef CTRL_PERF_COUNTERS_EN
        chk("reset_cycle_count", cc1, 32'd0);
        chk("reset_instret_count", ic1, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic bc, input int cls,
                       input logic [3:0] alu, input logic [1:0] a, input logic b);
        obs_t e;
        int   cyc = 0;
        opcode = op; funct3 = f3; funct7_5 = f7; branch_cond = bc;
        model(1, 1, cls, bc, alu, a, b);
        model(2, 2, cls, bc, alu, a, b);
        do_reset();
        while (q1.size() > 0 || q2.size() > 0) begin
            @(negedge clk);
            cyc++;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk($sformatf("%s L1 cycle%0d", tag, cyc), 32'(o1), 32'(e));
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk($sformatf("%s L2 cycle%0d", tag, cyc), 32'(o2), 32'(e));
            end
        end
    endtask

    initial begin
        obs_t e;
        reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; branch_cond = 1'b0;

        run("add",    7'b0110011, 3'b000, 1'b0, 1'(($urandom_range(0, 1))), C_ALU, ALU_ADD, 2'd0, 1'b0);
        run("beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, C_BR,  ALU_ADD, 2'd0, 1'b0);
        run("beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, C_BR,  ALU_ADD, 2'd0, 1'b0);
        run("lw",     7'b0000011, 3'b010, 1'b0, 1'b1, C_LD,  ALU_ADD, 2'd0, 1'b1);
        run("sw",     7'b0100011, 3'b010, 1'b0, 1'b1, C_ST,  ALU_ADD, 2'd0, 1'b1);
        run("jalr",   7'b1100111, 3'b000, 1'b0, 1'b1, C_JALR, ALU_ADD, 2'd0, 1'b1);
        run("srai",   7'b0010011, 3'b101, 1'b1, 1'b0, C_ALU, ALU_SRA, 2'd0, 1'b1);
        run("srli",   7'b0010011, 3'b101, 1'b0, 1'b0, C_ALU, ALU_SRL, 2'd0, 1'b1);
        run("addi_f7",7'b0010011, 3'b000, 1'b1, 1'b0, C_ALU, ALU_ADD, 2'd0, 1'b1);
        run("sub",    7'b0110011, 3'b000, 1'b1, 1'b1, C_ALU, ALU_SUB, 2'd0, 1'b0);
        run("and",    7'b0110011, 3'b111, 1'b0, 1'b0, C_ALU, ALU_AND, 2'd0, 1'b0);
        run("jal",    7'b1101111, 3'b000, 1'b0, 1'b1, C_JAL, ALU_ADD, 2'd1, 1'b1);
        run("lui",    7'b0110111, 3'b000, 1'b0, 1'b0, C_ALU, ALU_ADD, 2'd2, 1'b1);
        run("auipc",  7'b0010111, 3'b000, 1'b0, 1'b0, C_ALU, ALU_ADD, 2'd1, 1'b1);
        run("fence",  7'b0001111, 3'b000, 1'b0, 1'b0, C_NOP, ALU_ADD, 2'd0, 1'b0);
        run("ecall",  7'b1110011, 3'b000, 1'b0, 1'b1, C_NOP, ALU_ADD, 2'd0, 1'b0);
        run("illegal",7'b1111111, 3'b000, 1'b0, 1'b1, C_ILL, ALU_ADD, 2'd0, 1'b0);

        // Reset raised during the store's MEMORY cycle (cycle 5 at latency 1)
        opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0; branch_cond = 1'b0;
        do_reset();
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        e = '0; e.st = 3'd3;
        chk("rst_mid_store L1", 32'(o1), 32'(e));
        e = '0; e.st = 3'd2; e.src_b = 1'b1;
        chk("rst_mid_store L2", 32'(o2), 32'(e));
        @(negedge clk);
        chk("rst_after_store L1", 32'(o1), 32'd0);
        chk("rst_after_store L2", 32'(o2), 32'd0);
`ifdef CTRL_PERF_COUNTERS_EN
        chk("rst_after_store cycle_count", cc1, 32'd0);
        chk("rst_after_store instret_count", ic1, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
